// File: rtl/ofs_fim_tag_arb_pkg.sv
// Shared types and the round-robin pick function for the tag arbiter.
// Ports: none (package). Default widths describe the standard 4-requester, 32-tag build.
// rr_pick works on a zero-padded eligibility vector of up to RR_MAX_N requesters.
package ofs_fim_tag_arb_pkg;

    localparam int TAG_ARB_N_REQ           = 4;
    localparam int TAG_ARB_N_ENTRIES       = 32;
    localparam int TAG_ARB_MAX_OUTSTANDING = 16;

    localparam int RR_MAX_N = 32;
    localparam int RR_IDX_W = $clog2(RR_MAX_N);

    typedef logic [$clog2(TAG_ARB_N_ENTRIES)-1:0]         t_tag;
    typedef logic [$clog2(TAG_ARB_N_REQ)-1:0]             t_req_idx;
    typedef logic [$clog2(TAG_ARB_MAX_OUTSTANDING+1)-1:0] t_out_cnt;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } t_rr_pick;

    // First eligible index at or after ptr, wrapping modulo n (ptr < n <= RR_MAX_N).
    function automatic t_rr_pick rr_pick(
        input logic [RR_MAX_N-1:0] eligible,
        input int unsigned         ptr,
        input int unsigned         n
    );
        t_rr_pick    res;
        int unsigned j;
        res = '0;
        for (int unsigned k = 0; k < RR_MAX_N; k++) begin
            j = ptr + k;
            if (j >= n) begin
                j = j - n;
            end
            if (k < n) begin
                if (!res.found && eligible[j[RR_IDX_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = j[RR_IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ofs_fim_tag_arb_rr_arb.sv
// Round-robin arbiter: combinational winner selection from a registered pointer.
// Ports: eligible_i/advance_i in; found_o/idx_o combinational out (zero latency).
// Pointer moves to winner+1 (mod N) only on advance_i, otherwise it holds.
module ofs_fim_rr_arb
    import ofs_fim_tag_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         eligible_i,
    input  logic                 advance_i,
    output logic                 found_o,
    output logic [$clog2(N)-1:0] idx_o
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [RR_MAX_N-1:0] elig_ext;
    t_rr_pick            pick;

    always_comb begin
        elig_ext        = '0;
        elig_ext[N-1:0] = eligible_i;
        pick            = rr_pick(elig_ext, 32'(ptr_q), N);
    end

    assign found_o = pick.found;
    assign idx_o   = pick.idx[IDX_W-1:0];

    generate
        if (IDX_W < RR_IDX_W) begin : g_pad
            logic unused_pick_hi;
            assign unused_pick_hi = &{1'b0, pick.idx[RR_IDX_W-1:IDX_W]};
        end
    endgenerate

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = (idx_o == IDX_W'(N - 1)) ? '0 : idx_o + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ofs_fim_tag_arb.sv
// Tag arbiter: shares one PCIe TX tag pool among N_REQ requesters, tracks tag owners, caps in-flight tags.
// Ports: req_valid/req_ready/req_tag (zero-latency grant), pool alloc/free, cpl in -> cpl_owner out (1 cycle).
// Backpressure: no grant without pool_alloc_ready; requesters at MAX_OUTSTANDING are masked until a tag retires.
module ofs_fim_tag_arb
    import ofs_fim_tag_arb_pkg::*;
#(
    parameter int N_REQ           = TAG_ARB_N_REQ,
    parameter int N_ENTRIES       = TAG_ARB_N_ENTRIES,
    parameter int MAX_OUTSTANDING = TAG_ARB_MAX_OUTSTANDING
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic [N_REQ-1:0]                                 req_valid,
    output logic [N_REQ-1:0]                                 req_ready,
    output logic [$clog2(N_ENTRIES)-1:0]                     req_tag,
    output logic                                             pool_alloc,
    input  logic                                             pool_alloc_ready,
    input  logic [$clog2(N_ENTRIES)-1:0]                     pool_alloc_uid,
    output logic                                             pool_free,
    output logic [$clog2(N_ENTRIES)-1:0]                     pool_free_uid,
    input  logic                                             cpl_valid,
    input  logic [$clog2(N_ENTRIES)-1:0]                     cpl_tag,
    input  logic                                             cpl_last,
    output logic                                             cpl_owner_valid,
    output logic [$clog2(N_REQ)-1:0]                         cpl_owner,
    output logic [N_REQ*$clog2(MAX_OUTSTANDING+1)-1:0]       outstanding,
    output logic                                             err_spurious
);

    localparam int TAG_W = $clog2(N_ENTRIES);
    localparam int REQ_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0]     count_q [N_REQ];
    logic [CNT_W-1:0]     count_d [N_REQ];
    logic [N_ENTRIES-1:0] busy_q, busy_d;
    logic [REQ_W-1:0]     owner_q [N_ENTRIES];

    logic [N_REQ-1:0]     eligible;
    logic                 found;
    logic                 grant;
    logic [REQ_W-1:0]     win;

    logic                 cpl_hit;
    logic                 cpl_free;
    logic [REQ_W-1:0]     cpl_own;

    logic                 cpl_owner_valid_q;
    logic [REQ_W-1:0]     cpl_owner_q;
    logic                 pool_free_q;
    logic [TAG_W-1:0]     pool_free_uid_q;
    logic                 err_spurious_q;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = req_valid[i] && (count_q[i] < CNT_W'(MAX_OUTSTANDING));
        end
    end

    ofs_fim_rr_arb #(.N(N_REQ)) u_rr_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .eligible_i (eligible),
        .advance_i  (grant),
        .found_o    (found),
        .idx_o      (win)
    );

    // Grant is combinational; gating with rst_n keeps the handshake quiet while held in reset.
    assign grant      = rst_n && found && pool_alloc_ready;
    assign pool_alloc = grant;
    assign req_tag    = pool_alloc_uid;

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[win] = 1'b1;
        end
    end

    assign cpl_hit  = cpl_valid && busy_q[cpl_tag];
    assign cpl_free = cpl_hit && cpl_last;
    assign cpl_own  = owner_q[cpl_tag];

    // Grant and retire for the same requester net to zero. The zero guard on the
    // decrement only matters if busy tracking were ever corrupted.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            count_d[i] = count_q[i];
            if (grant && (win == REQ_W'(i))) begin
                count_d[i] = count_d[i] + CNT_W'(1);
            end
            if (cpl_free && (cpl_own == REQ_W'(i)) && (count_d[i] != '0)) begin
                count_d[i] = count_d[i] - CNT_W'(1);
            end
        end
    end

    // The pool never reissues a busy tag, so set and clear never target the same entry.
    always_comb begin
        busy_d = busy_q;
        if (cpl_free) begin
            busy_d[cpl_tag] = 1'b0;
        end
        if (grant) begin
            busy_d[pool_alloc_uid] = 1'b1;
        end
    end

    // Owner entries are meaningful only while busy, so they carry no reset.
    always_ff @(posedge clk) begin
        if (grant) begin
            owner_q[pool_alloc_uid] <= win;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                count_q[i] <= '0;
            end
            busy_q            <= '0;
            cpl_owner_valid_q <= 1'b0;
            cpl_owner_q       <= '0;
            pool_free_q       <= 1'b0;
            pool_free_uid_q   <= '0;
            err_spurious_q    <= 1'b0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                count_q[i] <= count_d[i];
            end
            busy_q            <= busy_d;
            cpl_owner_valid_q <= cpl_hit;
            cpl_owner_q       <= cpl_own;
            pool_free_q       <= cpl_free;
            if (cpl_free) begin
                pool_free_uid_q <= cpl_tag;
            end
            if (cpl_valid && !busy_q[cpl_tag]) begin
                err_spurious_q <= 1'b1;
            end
        end
    end

    assign cpl_owner_valid = cpl_owner_valid_q;
    assign cpl_owner       = cpl_owner_q;
    assign pool_free       = pool_free_q;
    assign pool_free_uid   = pool_free_uid_q;
    assign err_spurious    = err_spurious_q;

    generate
        for (genvar g = 0; g < N_REQ; g++) begin : g_out
            assign outstanding[g*CNT_W +: CNT_W] = count_q[g];
        end
    endgenerate

endmodule

// File: tb/tb_ofs_fim_tag_arb.sv
module tb_ofs_fim_tag_arb;

    localparam int MAXO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [4:0]  req_tag;
    logic        pool_alloc;
    logic        pool_alloc_ready;
    logic [4:0]  pool_alloc_uid;
    logic        pool_free;
    logic [4:0]  pool_free_uid;
    logic        cpl_valid;
    logic [4:0]  cpl_tag;
    logic        cpl_last;
    logic        cpl_owner_valid;
    logic [1:0]  cpl_owner;
    logic [19:0] outstanding;
    logic        err_spurious;

    int total = 0;
    int bad   = 0;

    // Reference state: pool free list, per-tag busy/owner, per-requester counts.
    int          cnt_m [4];
    logic        busy_m [32];
    logic [1:0]  owner_m [32];
    int          rr_m;
    logic        err_m;
    logic [4:0]  pool_q [$];

    typedef struct packed { logic [1:0] w; logic [4:0] tag; } g_t;
    typedef struct packed { logic v; logic [1:0] own; logic f; logic [4:0] uid; } c_t;
    g_t grant_sb [$];
    c_t cpl_sb [$];

    logic [3:0] obs_rdy;
    int         obs_w;
    logic [4:0] obs_tag;

    always #5 clk = ~clk;

    ofs_fim_tag_arb #(.N_REQ(4), .N_ENTRIES(32), .MAX_OUTSTANDING(MAXO)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_tag          (req_tag),
        .pool_alloc       (pool_alloc),
        .pool_alloc_ready (pool_alloc_ready),
        .pool_alloc_uid   (pool_alloc_uid),
        .pool_free        (pool_free),
        .pool_free_uid    (pool_free_uid),
        .cpl_valid        (cpl_valid),
        .cpl_tag          (cpl_tag),
        .cpl_last         (cpl_last),
        .cpl_owner_valid  (cpl_owner_valid),
        .cpl_owner        (cpl_owner),
        .outstanding      (outstanding),
        .err_spurious     (err_spurious)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic reset_model();
        for (int i = 0; i < 4; i++) cnt_m[i] = 0;
        for (int t = 0; t < 32; t++) busy_m[t] = 1'b0;
        rr_m  = 0;
        err_m = 1'b0;
        pool_q.delete();
        for (int t = 0; t < 32; t++) pool_q.push_back(5'(t));
        grant_sb.delete();
        cpl_sb.delete();
    endtask

    // One clock cycle: entered and left at a falling edge. Drives inputs, checks the
    // combinational grant, advances the model, then checks registered outputs.
    task automatic cyc(input logic [3:0] rv, input logic cv, input logic [4:0] ct,
                       input logic cl, input logic ardy);
        logic [3:0]  elig;
        logic [3:0]  exp_rdy;
        logic [4:0]  uid;
        logic [19:0] exp_out;
        logic        fnd;
        logic        hit;
        int          w;
        int          j;
        g_t          ge;
        c_t          ce;

        uid              = (pool_q.size() > 0) ? pool_q[0] : 5'd0;
        req_valid        = rv;
        cpl_valid        = cv;
        cpl_tag          = ct;
        cpl_last         = cl;
        pool_alloc_ready = ardy && (pool_q.size() > 0);
        pool_alloc_uid   = uid;

        for (int i = 0; i < 4; i++) elig[i] = rv[i] && (cnt_m[i] < MAXO);
        fnd = 1'b0;
        w   = 0;
        for (int k = 0; k < 4; k++) begin
            j = (rr_m + k) % 4;
            if (!fnd && elig[j]) begin
                fnd = 1'b1;
                w   = j;
            end
        end
        exp_rdy = '0;
        if (fnd && pool_alloc_ready) begin
            exp_rdy[w] = 1'b1;
            grant_sb.push_back({2'(w), uid});
        end

        #1;
        obs_rdy = req_ready;
        obs_tag = req_tag;
        obs_w   = -1;
        for (int i = 0; i < 4; i++) if (req_ready[i]) obs_w = i;

        total++;
        if (req_ready !== exp_rdy) begin
            bad++;
            $display("FAIL req_ready: got %b want %b", req_ready, exp_rdy);
        end
        total++;
        if (pool_alloc !== (exp_rdy != 4'b0)) begin
            bad++;
            $display("FAIL pool_alloc: got %b want %b", pool_alloc, (exp_rdy != 4'b0));
        end
        if (grant_sb.size() > 0) begin
            ge = grant_sb.pop_front();
            total++;
            if (req_tag !== ge.tag) begin
                bad++;
                $display("FAIL req_tag: got %0d want %0d", req_tag, ge.tag);
            end
        end

        hit = cv && busy_m[ct];
        cpl_sb.push_back({hit, owner_m[ct], hit && cl, ct});
        if (cv && !busy_m[ct]) err_m = 1'b1;
        if (hit && cl) begin
            busy_m[ct] = 1'b0;
            if (cnt_m[owner_m[ct]] == 0) begin
                total++;
                bad++;
                $display("FAIL count_underflow: requester %0d count 0 want >0", owner_m[ct]);
            end else begin
                cnt_m[owner_m[ct]]--;
            end
        end
        if (exp_rdy != 4'b0) begin
            owner_m[uid] = 2'(w);
            busy_m[uid]  = 1'b1;
            cnt_m[w]++;
            rr_m = (w + 1) % 4;
            void'(pool_q.pop_front());
        end

        @(negedge clk);
        ce = cpl_sb.pop_front();
        if (ce.f) pool_q.push_back(ce.uid);
        total++;
        if (cpl_owner_valid !== ce.v) begin
            bad++;
            $display("FAIL cpl_owner_valid: got %b want %b", cpl_owner_valid, ce.v);
        end
        if (ce.v) begin
            total++;
            if (cpl_owner !== ce.own) begin
                bad++;
                $display("FAIL cpl_owner: got %0d want %0d", cpl_owner, ce.own);
            end
        end
        total++;
        if (pool_free !== ce.f) begin
            bad++;
            $display("FAIL pool_free: got %b want %b", pool_free, ce.f);
        end
        if (ce.f) begin
            total++;
            if (pool_free_uid !== ce.uid) begin
                bad++;
                $display("FAIL pool_free_uid: got %0d want %0d", pool_free_uid, ce.uid);
            end
        end
        total++;
        if (err_spurious !== err_m) begin
            bad++;
            $display("FAIL err_spurious: got %b want %b", err_spurious, err_m);
        end
        for (int i = 0; i < 4; i++) exp_out[i*5 +: 5] = 5'(cnt_m[i]);
        total++;
        if (outstanding !== exp_out) begin
            bad++;
            $display("FAIL outstanding: got %h want %h", outstanding, exp_out);
        end
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        req_valid        = 4'b1111;
        pool_alloc_ready = 1'b1;
        pool_alloc_uid   = 5'd0;
        cpl_valid        = 1'b0;
        cpl_tag          = 5'd0;
        cpl_last         = 1'b0;
        reset_model();
        #17;
        total++;
        if (req_ready !== 4'b0 || pool_alloc !== 1'b0) begin
            bad++;
            $display("FAIL reset_grant: got rdy=%b alloc=%b want 0", req_ready, pool_alloc);
        end
        total++;
        if (pool_free !== 1'b0 || cpl_owner_valid !== 1'b0 || err_spurious !== 1'b0) begin
            bad++;
            $display("FAIL reset_regs: got free=%b ov=%b err=%b want 0", pool_free, cpl_owner_valid, err_spurious);
        end
        total++;
        if (outstanding !== 20'h0) begin
            bad++;
            $display("FAIL reset_outstanding: got %h want 0", outstanding);
        end
        req_valid = 4'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rr();
        int want_w [5] = '{0, 1, 2, 3, 0};
        for (int c = 0; c < 5; c++) begin
            cyc(4'b1111, 1'b0, 5'd0, 1'b0, 1'b1);
            total++;
            if (obs_w !== want_w[c] || obs_tag !== 5'(c)) begin
                bad++;
                $display("FAIL rr_order[%0d]: got req %0d tag %0d want req %0d tag %0d", c, obs_w, obs_tag, want_w[c], c);
            end
            if (c == 3) begin
                total++;
                if (outstanding !== {5'd1, 5'd1, 5'd1, 5'd1}) begin
                    bad++;
                    $display("FAIL rr_outstanding: got %h want %h", outstanding, {5'd1, 5'd1, 5'd1, 5'd1});
                end
            end
        end
    endtask

    task automatic test_cpl();
        cyc(4'b0010, 1'b0, 5'd0, 1'b0, 1'b1);
        total++;
        if (obs_w !== 1 || obs_tag !== 5'd5) begin
            bad++;
            $display("FAIL cpl_setup: got req %0d tag %0d want req 1 tag 5", obs_w, obs_tag);
        end
        // tags 0 and 4 both belong to requester 0
        cyc(4'b0000, 1'b1, 5'd4, 1'b0, 1'b1);
        total++;
        if (cpl_owner_valid !== 1'b1 || cpl_owner !== 2'd0) begin
            bad++;
            $display("FAIL owner_tag4: got v=%b own=%0d want v=1 own=0", cpl_owner_valid, cpl_owner);
        end
        cyc(4'b0000, 1'b1, 5'd0, 1'b0, 1'b1);
        total++;
        if (cpl_owner_valid !== 1'b1 || cpl_owner !== 2'd0) begin
            bad++;
            $display("FAIL owner_tag0: got v=%b own=%0d want v=1 own=0", cpl_owner_valid, cpl_owner);
        end
        cyc(4'b0000, 1'b1, 5'd5, 1'b0, 1'b1);
        total++;
        if (cpl_owner_valid !== 1'b1 || cpl_owner !== 2'd1 || pool_free !== 1'b0) begin
            bad++;
            $display("FAIL cpl_nonlast: got v=%b own=%0d free=%b want v=1 own=1 free=0", cpl_owner_valid, cpl_owner, pool_free);
        end
        cyc(4'b0000, 1'b1, 5'd5, 1'b1, 1'b1);
        total++;
        if (cpl_owner_valid !== 1'b1 || cpl_owner !== 2'd1 || pool_free !== 1'b1 || pool_free_uid !== 5'd5) begin
            bad++;
            $display("FAIL cpl_last: got v=%b own=%0d free=%b uid=%0d want 1 1 1 5", cpl_owner_valid, cpl_owner, pool_free, pool_free_uid);
        end
        total++;
        if (outstanding[9:5] !== 5'd1) begin
            bad++;
            $display("FAIL cpl_count1: got %0d want 1", outstanding[9:5]);
        end
        cyc(4'b0000, 1'b0, 5'd0, 1'b0, 1'b1);
        total++;
        if (pool_free !== 1'b0) begin
            bad++;
            $display("FAIL free_pulse: got %b want 0", pool_free);
        end
    endtask

    task automatic test_spurious();
        cyc(4'b0000, 1'b1, 5'd9, 1'b1, 1'b1);
        total++;
        if (err_spurious !== 1'b1 || cpl_owner_valid !== 1'b0 || pool_free !== 1'b0) begin
            bad++;
            $display("FAIL spurious: got err=%b ov=%b free=%b want 1 0 0", err_spurious, cpl_owner_valid, pool_free);
        end
        cyc(4'b0000, 1'b0, 5'd0, 1'b0, 1'b1);
        cyc(4'b0000, 1'b0, 5'd0, 1'b0, 1'b1);
        total++;
        if (err_spurious !== 1'b1) begin
            bad++;
            $display("FAIL spurious_sticky: got %b want 1", err_spurious);
        end
    endtask

    task automatic test_max();
        int ng = 0;
        for (int i = 0; i < 40 && cnt_m[2] < MAXO; i++) begin
            cyc(4'b0100, 1'b0, 5'd0, 1'b0, 1'b1);
            if (obs_rdy === 4'b0100) ng++;
        end
        total++;
        if (ng != 15 || outstanding[14:10] !== 5'd16) begin
            bad++;
            $display("FAIL max_fill: got grants=%0d cnt=%0d want 15 16", ng, outstanding[14:10]);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0100, 1'b0, 5'd0, 1'b0, 1'b1);
            total++;
            if (obs_rdy !== 4'b0000) begin
                bad++;
                $display("FAIL max_masked: got %b want 0000", obs_rdy);
            end
        end
        cyc(4'b0100, 1'b1, 5'd2, 1'b1, 1'b1);
        total++;
        if (obs_rdy !== 4'b0000 || pool_free !== 1'b1 || pool_free_uid !== 5'd2) begin
            bad++;
            $display("FAIL max_retire: got rdy=%b free=%b uid=%0d want 0000 1 2", obs_rdy, pool_free, pool_free_uid);
        end
        cyc(4'b0100, 1'b0, 5'd0, 1'b0, 1'b1);
        total++;
        if (obs_rdy !== 4'b0100) begin
            bad++;
            $display("FAIL max_regrant: got %b want 0100", obs_rdy);
        end
    endtask

    task automatic test_simul();
        cyc(4'b1000, 1'b1, 5'd3, 1'b1, 1'b1);
        total++;
        if (obs_rdy !== 4'b1000 || outstanding[19:15] !== 5'd1) begin
            bad++;
            $display("FAIL simul: got rdy=%b cnt3=%0d want 1000 1", obs_rdy, outstanding[19:15]);
        end
        total++;
        if (pool_free !== 1'b1 || pool_free_uid !== 5'd3) begin
            bad++;
            $display("FAIL simul_free: got free=%b uid=%0d want 1 3", pool_free, pool_free_uid);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            cyc(4'b1111, 1'b0, 5'd0, 1'b0, 1'b1);
            total++;
            if (obs_rdy[2] !== 1'b0 || obs_rdy === 4'b0000) begin
                bad++;
                $display("FAIL b2b_mask: got %b want one-hot without bit 2", obs_rdy);
            end
        end
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (req_ready !== 4'b0 || pool_alloc !== 1'b0 || pool_free !== 1'b0 || cpl_owner_valid !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_out: got rdy=%b alloc=%b free=%b ov=%b want 0", req_ready, pool_alloc, pool_free, cpl_owner_valid);
        end
        total++;
        if (err_spurious !== 1'b0 || outstanding !== 20'h0) begin
            bad++;
            $display("FAIL async_reset_state: got err=%b out=%h want 0 0", err_spurious, outstanding);
        end
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4'b1111, 1'b0, 5'd0, 1'b0, 1'b1);
        total++;
        if (obs_w !== 0 || obs_tag !== 5'd0) begin
            bad++;
            $display("FAIL restart0: got req %0d tag %0d want 0 0", obs_w, obs_tag);
        end
        cyc(4'b1111, 1'b0, 5'd0, 1'b0, 1'b1);
        total++;
        if (obs_w !== 1 || obs_tag !== 5'd1) begin
            bad++;
            $display("FAIL restart1: got req %0d tag %0d want 1 1", obs_w, obs_tag);
        end
    endtask

    initial begin
        test_reset();
        test_rr();
        test_cpl();
        test_spurious();
        test_max();
        test_simul();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
